// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states,
// the MEM/WB register layout and its bubble value.
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] alu_out;
        logic [31:0] mem_data;
        logic        reg_write;
        logic [1:0]  mem_to_reg;
    } wb_t;

    // A bubble never writes the register file; remaining fields are zeroed.
    localparam wb_t WB_BUBBLE = '0;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
interface mem_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures the stage result when load=1,
// otherwise inserts a bubble.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  wb_t  d,
    output wb_t  q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= WB_BUBBLE;
        end else if (load) begin
            q <= d;
        end else begin
            q <= WB_BUBBLE;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory accesses, stalls the pipeline while
// waiting, aborts on misalignment or timeout, and feeds the MEM/WB register.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         MEMrd,
    input  logic [31:0]        MEMPC,
    input  logic [31:0]        MEMALUOut,
    input  logic [31:0]        MEMDatabus3,
    input  logic               MEMRegWrite,
    input  logic               MEMMemRead,
    input  logic               MEMMemWrite,
    input  logic [1:0]         MEMMemtoReg,
    mem_access_stage_if.master mem,
    output logic               Stall,
    output logic               MemFault,
    output logic [4:0]         WBrd,
    output logic [31:0]        WBPC,
    output logic [31:0]        WBALUOut,
    output logic [31:0]        WBMemData,
    output logic               WBRegWrite,
    output logic [1:0]         WBMemtoReg
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       acc, mis;
    logic       stall_c, fault_c, req_c, wb_load, use_rdata;
    wb_t        wb_d, wb_q;

    assign acc = MEMMemRead | MEMMemWrite;
    assign mis = acc & is_misaligned(MEMALUOut[1:0]);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_c    = 1'b0;
        fault_c    = 1'b0;
        req_c      = 1'b0;
        wb_load    = 1'b0;
        use_rdata  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (acc && !mis) begin
                    state_next = WAIT;
                    stall_c    = 1'b1;
                end else if (mis) begin
                    fault_c = 1'b1;
                end else begin
                    wb_load = 1'b1;
                end
            end
            WAIT: begin
                req_c = 1'b1;
                // A completion in the last allowed cycle wins over the timeout.
                if (mem.mem_ready) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    wb_load    = 1'b1;
                    use_rdata  = MEMMemRead;
                end else if (cnt_reg == LAST_WAIT) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    fault_c    = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                    stall_c  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Control outputs are forced low while reset is held.
    assign Stall         = reset & stall_c;
    assign MemFault      = reset & fault_c;
    assign mem.mem_req   = reset & req_c;
    assign mem.mem_we    = mem.mem_req & MEMMemWrite;
    assign mem.mem_addr  = mem.mem_req ? MEMALUOut   : 32'd0;
    assign mem.mem_wdata = mem.mem_req ? MEMDatabus3 : 32'd0;

    always_comb begin
        wb_d            = WB_BUBBLE;
        wb_d.rd         = MEMrd;
        wb_d.pc         = MEMPC;
        wb_d.alu_out    = MEMALUOut;
        wb_d.mem_data   = use_rdata ? mem.mem_rdata : 32'd0;
        wb_d.reg_write  = MEMRegWrite;
        wb_d.mem_to_reg = MEMMemtoReg;
    end

    mem_wb_reg u_wb_reg (
        .clk   (clk),
        .reset (reset),
        .load  (wb_load),
        .d     (wb_d),
        .q     (wb_q)
    );

    assign WBrd       = wb_q.rd;
    assign WBPC       = wb_q.pc;
    assign WBALUOut   = wb_q.alu_out;
    assign WBMemData  = wb_q.mem_data;
    assign WBRegWrite = wb_q.reg_write;
    assign WBMemtoReg = wb_q.mem_to_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  MEMrd;
    logic [31:0] MEMPC, MEMALUOut, MEMDatabus3;
    logic        MEMRegWrite, MEMMemRead, MEMMemWrite;
    logic [1:0]  MEMMemtoReg;
    logic        Stall, MemFault;
    logic [4:0]  WBrd;
    logic [31:0] WBPC, WBALUOut, WBMemData;
    logic        WBRegWrite;
    logic [1:0]  WBMemtoReg;

    mem_access_stage_if mem_bus();

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .MEMrd       (MEMrd),
        .MEMPC       (MEMPC),
        .MEMALUOut   (MEMALUOut),
        .MEMDatabus3 (MEMDatabus3),
        .MEMRegWrite (MEMRegWrite),
        .MEMMemRead  (MEMMemRead),
        .MEMMemWrite (MEMMemWrite),
        .MEMMemtoReg (MEMMemtoReg),
        .mem         (mem_bus),
        .Stall       (Stall),
        .MemFault    (MemFault),
        .WBrd        (WBrd),
        .WBPC        (WBPC),
        .WBALUOut    (WBALUOut),
        .WBMemData   (WBMemData),
        .WBRegWrite  (WBRegWrite),
        .WBMemtoReg  (WBMemtoReg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // busy: an access is outstanding; waited: cycles already spent waiting.
    bit          m_busy   = 0;
    int          m_waited = 0;
    bit          m_hold   = 0;
    logic [4:0]  e_rd  = '0;
    logic [31:0] e_pc  = '0, e_alu = '0, e_md = '0;
    logic        e_rw  = 1'b0;
    logic [1:0]  e_m2r = '0;

    task model_wb(input bit take, input logic [31:0] md);
        e_rd  = take ? MEMrd       : 5'd0;
        e_pc  = take ? MEMPC       : 32'd0;
        e_alu = take ? MEMALUOut   : 32'd0;
        e_md  = take ? md          : 32'd0;
        e_rw  = take ? MEMRegWrite : 1'b0;
        e_m2r = take ? MEMMemtoReg : 2'd0;
    endtask

    always @(posedge clk) begin
        bit acc, mis, rdy;
        acc = MEMMemRead || MEMMemWrite;
        mis = acc && (MEMALUOut % 4 != 0);
        rdy = mem_bus.mem_ready;
        m_hold = reset && (m_busy ? (!rdy && m_waited < TO - 1) : (acc && !mis));
        if (!reset) begin
            m_busy = 0; m_waited = 0; model_wb(0, 0);
        end else if (!m_busy) begin
            if (acc && !mis) begin
                m_busy = 1; m_waited = 0; model_wb(0, 0);
            end else if (mis) begin
                model_wb(0, 0);
            end else begin
                model_wb(1, 0);
            end
        end else if (rdy) begin
            m_busy = 0; m_waited = 0;
            model_wb(1, MEMMemRead ? mem_bus.mem_rdata : 32'd0);
        end else if (m_waited == TO - 1) begin
            m_busy = 0; m_waited = 0; model_wb(0, 0);
        end else begin
            m_waited++; model_wb(0, 0);
        end
    end

    always @(negedge clk) begin
        bit acc, mis, req, st, flt;
        acc = MEMMemRead || MEMMemWrite;
        mis = acc && (MEMALUOut % 4 != 0);
        req = reset && m_busy;
        st  = reset && (m_busy ? (!mem_bus.mem_ready && m_waited < TO - 1) : (acc && !mis));
        flt = reset && (m_busy ? (!mem_bus.mem_ready && m_waited == TO - 1) : mis);
        check("m_stall", Stall, st);
        check("m_fault", MemFault, flt);
        check("m_req",   mem_bus.mem_req, req);
        check("m_we",    mem_bus.mem_we, req && MEMMemWrite);
        check("m_addr",  mem_bus.mem_addr, req ? MEMALUOut : 32'd0);
        check("m_wdata", mem_bus.mem_wdata, req ? MEMDatabus3 : 32'd0);
        check("m_wbrd",  WBrd, e_rd);
        check("m_wbpc",  WBPC, e_pc);
        check("m_wbalu", WBALUOut, e_alu);
        check("m_wbmd",  WBMemData, e_md);
        check("m_wbrw",  WBRegWrite, e_rw);
        check("m_wbm2r", WBMemtoReg, e_m2r);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] alu,
                             input logic [31:0] data, input logic rw, input logic mr,
                             input logic mw, input logic [1:0] m2r);
        MEMrd = rd; MEMPC = pc; MEMALUOut = alu; MEMDatabus3 = data;
        MEMRegWrite = rw; MEMMemRead = mr; MEMMemWrite = mw; MEMMemtoReg = m2r;
    endtask

    task automatic nop();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int stall_cnt, fault_cnt, fault_at;
        reset = 1'b0;
        nop();
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 32'd0;
        step(); step();

        // Reset state, with a pending load on the inputs.
        check("rst_wbrd", WBrd, 0);
        check("rst_wbrw", WBRegWrite, 0);
        check("rst_wbpc", WBPC, 0);
        set_instr(1, 32'h20, 32'h100, 0, 1, 1, 0, 1);
        @(negedge clk);
        check("rst_stall", Stall, 0);
        check("rst_req", mem_bus.mem_req, 0);
        step();
        reset = 1'b1;
        nop();
        $display("scenario reset: done");

        // ALU op passes straight through.
        set_instr(5, 32'h40, 32'h10, 0, 1, 0, 0, 0);
        @(negedge clk);
        check("alu_stall", Stall, 0);
        step();
        check("alu_wbrd", WBrd, 5);
        check("alu_wbalu", WBALUOut, 32'h10);
        check("alu_wbrw", WBRegWrite, 1);
        check("alu_wbmd", WBMemData, 0);
        nop();
        $display("scenario alu op: done");

        // Load with ready three cycles after the request rises.
        set_instr(7, 32'h44, 32'h100, 0, 1, 1, 0, 1);
        stall_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                mem_bus.mem_ready = 1'b1;
                mem_bus.mem_rdata = 32'hDEADBEEF;
            end
            @(negedge clk);
            if (Stall) stall_cnt++;
            if (i == 1) check("ld_req", mem_bus.mem_req, 1);
            step();
        end
        mem_bus.mem_ready = 1'b0;
        check("ld_stall_cycles", stall_cnt, 4);
        check("ld_wbmd", WBMemData, 32'hDEADBEEF);
        check("ld_wbrw", WBRegWrite, 1);
        check("ld_wbrd", WBrd, 7);
        nop();
        $display("scenario load: done");

        // Misaligned store faults without a request.
        set_instr(3, 32'h48, 32'h102, 32'hCAFE, 0, 0, 1, 0);
        @(negedge clk);
        check("mis_req", mem_bus.mem_req, 0);
        check("mis_fault", MemFault, 1);
        step();
        check("mis_wbrw", WBRegWrite, 0);
        nop();
        @(negedge clk);
        check("mis_fault_pulse", MemFault, 0);
        step();
        $display("scenario misaligned store: done");

        // Timeout with ready held low.
        set_instr(9, 32'h4C, 32'h200, 0, 1, 1, 0, 1);
        stall_cnt = 0; fault_at = -1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (MemFault && fault_at < 0) fault_at = i;
            if (Stall) stall_cnt++;
            step();
        end
        check("to_fault_cycle", fault_at, 4);
        check("to_stall_cycles", stall_cnt, 4);
        check("to_wbrw", WBRegWrite, 0);
        nop();
        @(negedge clk);
        check("to_idle_req", mem_bus.mem_req, 0);
        step();
        $display("scenario timeout: done");

        // Ready in the last allowed wait cycle completes normally.
        set_instr(11, 32'h50, 32'h204, 0, 1, 1, 0, 1);
        fault_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                mem_bus.mem_ready = 1'b1;
                mem_bus.mem_rdata = 32'h12345678;
            end
            @(negedge clk);
            if (MemFault) fault_cnt++;
            step();
        end
        mem_bus.mem_ready = 1'b0;
        check("late_faults", fault_cnt, 0);
        check("late_wbmd", WBMemData, 32'h12345678);
        check("late_wbrw", WBRegWrite, 1);
        nop();
        $display("scenario late ready: done");

        // Reset during the second wait cycle aborts the access.
        set_instr(13, 32'h54, 32'h300, 0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) reset = 1'b0;
            @(negedge clk);
            if (i == 2) begin
                check("rw_stall", Stall, 0);
                check("rw_req", mem_bus.mem_req, 0);
                check("rw_fault", MemFault, 0);
            end
            step();
        end
        check("rw_wbrd", WBrd, 0);
        check("rw_wbrw", WBRegWrite, 0);
        reset = 1'b1;
        nop();
        @(negedge clk);
        check("rw_idle_req", mem_bus.mem_req, 0);
        step();
        $display("scenario reset in wait: done");

        // Randomized traffic; the model compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) != 0);
            mem_bus.mem_ready = ($urandom_range(0, 99) < 30);
            mem_bus.mem_rdata = $urandom;
            if (!m_hold) begin
                logic [31:0] a;
                a = $urandom;
                case ($urandom_range(0, 3))
                    0: set_instr(5'($urandom), $urandom, a, $urandom, 1'($urandom), 0, 0, 2'($urandom));
                    1: set_instr(5'($urandom), $urandom, {a[31:2], 2'b00}, $urandom, 1, 1, 0, 1);
                    2: set_instr(5'($urandom), $urandom, {a[31:2], 2'b00}, $urandom, 0, 0, 1, 0);
                    default: set_instr(5'($urandom), $urandom, {a[31:2], 2'($urandom_range(1, 3))},
                                       $urandom, 1'($urandom), a[0], ~a[0], 2'($urandom));
                endcase
            end
            step();
        end
        $display("scenario random: 3000 cycles issued");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
